// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of ready RS entries onto the shared integer ALU pool.
// Each ALU holds a small FSM that keeps it reserved while a load/store address waits on memory.
module alu_issue_arbiter #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned NUM_ALU = 3,
    parameter int unsigned REQ_W   = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [4*NUM_REQ-1:0]     i_req_optype,
    input  logic [NUM_ALU-1:0]       i_mem_done,
    input  logic                     i_flush,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_ALU-1:0]       o_alu_number,
    output logic [REQ_W*NUM_ALU-1:0] o_alu_req_idx,
    output logic [4*NUM_ALU-1:0]     o_alu_optype,
    output logic [NUM_ALU-1:0]       o_alu_busy,
    output logic                     o_err_illegal
);

    localparam int unsigned OP_W = 4;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MEM_WAIT = 1'b1
    } alu_state_e;

    alu_state_e                 r_state    [NUM_ALU];
    alu_state_e                 w_state_nxt[NUM_ALU];

    logic [NUM_REQ-1:0]         r_grant;
    logic [NUM_ALU-1:0]         r_alu_number;
    logic [REQ_W*NUM_ALU-1:0]   r_alu_req_idx;
    logic [OP_W*NUM_ALU-1:0]    r_alu_optype;
    logic [NUM_ALU-1:0]         r_alu_busy;
    logic                       r_err_illegal;
    logic [REQ_W-1:0]           r_rr_ptr;

    logic [NUM_REQ-1:0]         w_elig;
    logic                       w_illegal;
    logic [NUM_ALU-1:0]         w_free;
    logic [NUM_REQ-1:0]         w_grant;
    logic [NUM_ALU-1:0]         w_alu_num;
    logic [REQ_W*NUM_ALU-1:0]   w_alu_idx;
    logic [OP_W*NUM_ALU-1:0]    w_alu_opt;
    logic [REQ_W-1:0]           w_last;
    logic                       w_any;
    logic [REQ_W-1:0]           w_scan;
    logic                       w_placed;
    logic [REQ_W-1:0]           w_rr_nxt;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op >= 4'd1) && (op <= 4'd10);
    endfunction

    function automatic logic op_is_mem(input logic [OP_W-1:0] op);
        return (op >= 4'd7) && (op <= 4'd10);
    endfunction

    // Entries granted last cycle are masked: the requester only sees grant one cycle late.
    always_comb begin
        w_elig    = '0;
        w_illegal = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = i_req_valid[i] && op_legal(i_req_optype[OP_W*i +: OP_W]) && !r_grant[i];
            w_illegal = w_illegal | (i_req_valid[i] && !op_legal(i_req_optype[OP_W*i +: OP_W]));
        end
    end

    // Walk entries from rr_ptr; each eligible one takes the lowest still-free ALU.
    always_comb begin
        w_free    = '0;
        w_grant   = '0;
        w_alu_num = '0;
        w_alu_idx = '0;
        w_alu_opt = '0;
        w_last    = r_rr_ptr;
        w_any     = 1'b0;
        w_scan    = '0;
        w_placed  = 1'b0;
        for (int k = 0; k < NUM_ALU; k++) begin
            w_free[k] = (r_state[k] == S_IDLE);
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            w_scan   = REQ_W'((32'(r_rr_ptr) + 32'(j)) % NUM_REQ);
            w_placed = 1'b0;
            if (w_elig[w_scan]) begin
                for (int k = 0; k < NUM_ALU; k++) begin
                    if (!w_placed && w_free[k]) begin
                        w_placed                     = 1'b1;
                        w_free[k]                    = 1'b0;
                        w_alu_num[k]                 = 1'b1;
                        w_alu_idx[REQ_W*k +: REQ_W]  = w_scan;
                        w_alu_opt[OP_W*k +: OP_W]    = i_req_optype[OP_W*w_scan +: OP_W];
                        w_grant[w_scan]              = 1'b1;
                        w_last                       = w_scan;
                        w_any                        = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (i_flush) begin
            w_rr_nxt = '0;
        end else if (w_any) begin
            w_rr_nxt = (w_last == REQ_W'(NUM_REQ - 1)) ? '0 : w_last + REQ_W'(1);
        end
    end

    // Per-ALU next state: memory ops reserve the ALU until mem_done.
    always_comb begin
        for (int k = 0; k < NUM_ALU; k++) begin
            w_state_nxt[k] = r_state[k];
            if (i_flush) begin
                w_state_nxt[k] = S_IDLE;
            end else begin
                case (r_state[k])
                    S_IDLE: begin
                        if (w_alu_num[k] && op_is_mem(w_alu_opt[OP_W*k +: OP_W])) begin
                            w_state_nxt[k] = S_MEM_WAIT;
                        end
                    end
                    S_MEM_WAIT: begin
                        if (i_mem_done[k]) begin
                            w_state_nxt[k] = S_IDLE;
                        end
                    end
                    default: w_state_nxt[k] = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_ALU; k++) begin
                r_state[k] <= S_IDLE;
            end
        end else begin
            for (int k = 0; k < NUM_ALU; k++) begin
                r_state[k] <= w_state_nxt[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant       <= '0;
            r_alu_number  <= '0;
            r_alu_req_idx <= '0;
            r_alu_optype  <= '0;
            r_alu_busy    <= '0;
            r_err_illegal <= 1'b0;
            r_rr_ptr      <= '0;
        end else begin
            r_err_illegal <= r_err_illegal | w_illegal;
            r_rr_ptr      <= w_rr_nxt;
            for (int k = 0; k < NUM_ALU; k++) begin
                r_alu_busy[k] <= (w_state_nxt[k] == S_MEM_WAIT);
            end
            if (i_flush) begin
                r_grant       <= '0;
                r_alu_number  <= '0;
                r_alu_req_idx <= '0;
                r_alu_optype  <= '0;
            end else begin
                r_grant       <= w_grant;
                r_alu_number  <= w_alu_num;
                r_alu_req_idx <= w_alu_idx;
                r_alu_optype  <= w_alu_opt;
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_alu_number  = r_alu_number;
    assign o_alu_req_idx = r_alu_req_idx;
    assign o_alu_optype  = r_alu_optype;
    assign o_alu_busy    = r_alu_busy;
    assign o_err_illegal = r_err_illegal;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the issue rules.
module tb_alu_issue_arbiter;

    localparam int NR = 8;
    localparam int NA = 3;
    localparam int RW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [4*NR-1:0]   req_optype;
    logic [NA-1:0]     mem_done;
    logic              flush;
    logic [NR-1:0]     grant;
    logic [NA-1:0]     alu_number;
    logic [RW*NA-1:0]  alu_req_idx;
    logic [4*NA-1:0]   alu_optype;
    logic [NA-1:0]     alu_busy;
    logic              err_illegal;

    alu_issue_arbiter #(.NUM_REQ(NR), .NUM_ALU(NA), .REQ_W(RW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_optype (req_optype),
        .i_mem_done   (mem_done),
        .i_flush      (flush),
        .o_grant      (grant),
        .o_alu_number (alu_number),
        .o_alu_req_idx(alu_req_idx),
        .o_alu_optype (alu_optype),
        .o_alu_busy   (alu_busy),
        .o_err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_busy  [NA];
    bit m_pgrant[NR];
    int m_rr;
    bit m_err;

    logic [NR-1:0]    e_grant;
    logic [NA-1:0]    e_num;
    logic [RW*NA-1:0] e_idx;
    logic [4*NA-1:0]  e_opt;
    logic [NA-1:0]    e_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ops_all(input logic [3:0] o);
        return {8{o}};
    endfunction

    function automatic logic [31:0] put_op(input logic [31:0] b, input int i, input logic [3:0] o);
        logic [31:0] r;
        r = b;
        r[4*i +: 4] = o;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NA; k++) m_busy[k] = 1'b0;
        for (int i = 0; i < NR; i++) m_pgrant[i] = 1'b0;
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    // Pair eligible entries (in rotation order) with free ALUs (in index order).
    task automatic model_eval(input logic [7:0] v, input logic [31:0] op, input logic [2:0] md,
                              input logic fl);
        int elig[$];
        int freeq[$];
        int n;
        int i;
        logic [3:0] o;
        e_grant = '0; e_num = '0; e_idx = '0; e_opt = '0;
        for (int k = 0; k < NA; k++) if (!m_busy[k]) freeq.push_back(k);
        for (int j = 0; j < NR; j++) begin
            i = (m_rr + j) % NR;
            o = op[4*i +: 4];
            if (v[i] && o >= 1 && o <= 10 && !m_pgrant[i]) elig.push_back(i);
        end
        for (int x = 0; x < NR; x++) begin
            o = op[4*x +: 4];
            if (v[x] && (o == 0 || o > 10)) m_err = 1'b1;
        end
        n = (elig.size() < freeq.size()) ? elig.size() : freeq.size();
        if (fl) begin
            for (int k = 0; k < NA; k++) m_busy[k] = 1'b0;
            for (int x = 0; x < NR; x++) m_pgrant[x] = 1'b0;
            m_rr = 0;
        end else begin
            for (int g = 0; g < n; g++) begin
                e_grant[elig[g]]        = 1'b1;
                e_num[freeq[g]]         = 1'b1;
                e_idx[3*freeq[g] +: 3]  = 3'(elig[g]);
                e_opt[4*freeq[g] +: 4]  = op[4*elig[g] +: 4];
            end
            for (int k = 0; k < NA; k++) if (m_busy[k] && md[k]) m_busy[k] = 1'b0;
            for (int g = 0; g < n; g++) begin
                o = op[4*elig[g] +: 4];
                if (o >= 7) m_busy[freeq[g]] = 1'b1;
            end
            if (n > 0) m_rr = (elig[n-1] + 1) % NR;
            for (int x = 0; x < NR; x++) m_pgrant[x] = e_grant[x];
        end
        for (int k = 0; k < NA; k++) e_busy[k] = m_busy[k];
    endtask

    task automatic cyc(input logic [7:0] v, input logic [31:0] op, input logic [2:0] md,
                       input logic fl);
        req_valid  = v;
        req_optype = op;
        mem_done   = md;
        flush      = fl;
        model_eval(v, op, md, fl);
        @(posedge clk);
        #1;
        check("grant",       32'(grant),       32'(e_grant));
        check("alu_number",  32'(alu_number),  32'(e_num));
        check("alu_req_idx", 32'(alu_req_idx), 32'(e_idx));
        check("alu_optype",  32'(alu_optype),  32'(e_opt));
        check("alu_busy",    32'(alu_busy),    32'(e_busy));
        check("err_illegal", 32'(err_illegal), 32'(m_err));
    endtask

    initial begin
        logic [31:0] op;
        rst = 1'b1; req_valid = '0; req_optype = '0; mem_done = '0; flush = 1'b0;
        model_reset();
        #1;
        check("rst_grant",  32'(grant),       32'h0);
        check("rst_number", 32'(alu_number),  32'h0);
        check("rst_busy",   32'(alu_busy),    32'h0);
        check("rst_err",    32'(err_illegal), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fill all three ALUs, then rotate.
        cyc(8'h0F, ops_all(4'd1), 3'b000, 1'b0);
        check("fill_grant", 32'(grant), 32'h07);
        check("fill_idx",   32'(alu_req_idx), 32'h088);
        cyc(8'h08, ops_all(4'd1), 3'b000, 1'b0);
        check("rot_grant",  32'(grant), 32'h08);
        check("rot_number", 32'(alu_number), 32'h1);
        cyc(8'hFF, ops_all(4'd1), 3'b000, 1'b0);
        check("rot_ptr4",   32'(grant), 32'h70);

        // Memory hold on ALU0; release takes effect one cycle later.
        cyc(8'h00, ops_all(4'd1), 3'b000, 1'b0);
        cyc(8'h20, put_op(ops_all(4'd1), 5, 4'd8), 3'b000, 1'b0);
        check("hold_busy", 32'(alu_busy), 32'h1);
        cyc(8'h01, ops_all(4'd1), 3'b000, 1'b0);
        check("hold_alu1", 32'(alu_number), 32'h2);
        cyc(8'h00, ops_all(4'd1), 3'b000, 1'b0);
        cyc(8'h01, ops_all(4'd1), 3'b001, 1'b0);
        check("done_no_reuse", 32'(alu_number), 32'h2);
        check("done_busy",     32'(alu_busy), 32'h0);
        cyc(8'h02, ops_all(4'd1), 3'b000, 1'b0);
        check("reuse_alu0",    32'(alu_number), 32'h1);

        // Saturation: all ALUs waiting on memory.
        cyc(8'h00, ops_all(4'd1), 3'b000, 1'b1);
        cyc(8'h07, ops_all(4'd8), 3'b000, 1'b0);
        check("sat_busy", 32'(alu_busy), 32'h7);
        cyc(8'hC0, ops_all(4'd1), 3'b000, 1'b0);
        check("sat_hold0", 32'(grant), 32'h0);
        cyc(8'hC0, ops_all(4'd1), 3'b000, 1'b0);
        cyc(8'hC0, ops_all(4'd1), 3'b010, 1'b0);
        check("sat_hold1", 32'(grant), 32'h0);
        cyc(8'hC0, ops_all(4'd1), 3'b000, 1'b0);
        check("sat_grant6", 32'(grant), 32'h40);
        check("sat_alu1",   32'(alu_number), 32'h2);

        // Flush with requests pending, then resume from entry 0.
        cyc(8'h0F, ops_all(4'd1), 3'b000, 1'b1);
        check("flush_grant", 32'(grant), 32'h0);
        check("flush_busy",  32'(alu_busy), 32'h0);
        cyc(8'h0F, ops_all(4'd1), 3'b000, 1'b0);
        check("flush_resume", 32'(grant), 32'h07);

        // Asynchronous reset while ALU0 is held.
        cyc(8'h00, ops_all(4'd1), 3'b000, 1'b0);
        cyc(8'h02, ops_all(4'd7), 3'b000, 1'b0);
        check("pre_rst_busy", 32'(alu_busy), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("arst_busy",   32'(alu_busy),   32'h0);
        check("arst_grant",  32'(grant),      32'h0);
        check("arst_number", 32'(alu_number), 32'h0);
        model_reset();
        #2 rst = 1'b0;
        cyc(8'hFF, ops_all(4'd1), 3'b000, 1'b0);
        check("post_rst_grant", 32'(grant), 32'h07);

        // Random legal traffic.
        for (int c = 0; c < 1500; c++) begin
            op = '0;
            for (int i = 0; i < NR; i++) op[4*i +: 4] = 4'($urandom_range(1, 10));
            cyc(8'($urandom), op, 3'($urandom & $urandom), ($urandom_range(0, 31) == 0));
        end

        // Illegal optype is never granted and sets a sticky error.
        cyc(8'h00, ops_all(4'd1), 3'b000, 1'b1);
        op = put_op(put_op(ops_all(4'd1), 2, 4'd12), 3, 4'd5);
        cyc(8'h0C, op, 3'b000, 1'b0);
        check("illegal_grant", 32'(grant), 32'h08);
        check("illegal_err",   32'(err_illegal), 32'h1);
        cyc(8'h00, ops_all(4'd1), 3'b000, 1'b0);
        cyc(8'h00, ops_all(4'd1), 3'b000, 1'b1);
        check("illegal_sticky", 32'(err_illegal), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
